// File: rtl/round_robin_grant_generator_if.sv
// Handshake bundle between requesters/consumer and the round-robin grant generator.
// The master side drives requests/done; the slave side (the arbiter) drives the selectors.
interface round_robin_grant_generator_if #(
   parameter int REQUESTER_COUNT = 4,
   parameter int INDEX_WIDTH     = 2
);
   logic [REQUESTER_COUNT-1:0] requests;
   logic                       done;
   logic [REQUESTER_COUNT-1:0] grant;
   logic                       grant_valid;
   logic [INDEX_WIDTH-1:0]     grant_index;

   modport master (
      output requests,
      output done,
      input  grant,
      input  grant_valid,
      input  grant_index
   );

   modport slave (
      input  requests,
      input  done,
      output grant,
      output grant_valid,
      output grant_index
   );
endinterface

// File: rtl/round_robin_grant_generator.sv
// Round-robin arbiter producing registered one-hot selectors for a downstream one-hot mux.
// Grant is held until done or until the grantee drops its request; priority then rotates past it.
//
// state   | meaning
// IDLE    | no grant outstanding, arbitrate from the stored pointer
// GRANTED | grant held; on release rotate pointer past grantee and re-arbitrate same edge
module round_robin_grant_generator #(
   parameter int REQUESTER_COUNT = 4,
   parameter int INDEX_WIDTH     = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   round_robin_grant_generator_if.slave bus
);
   localparam int N = REQUESTER_COUNT;

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t                 state;
   logic [N-1:0]           ptr;
   logic [N-1:0]           rot_grant;
   logic [N-1:0]           search_ptr;
   logic [N-1:0]           mask_lo;
   logic [N-1:0]           winner;
   logic [2*N-1:0]         doubled;
   logic [2*N-1:0]         first;
   logic [INDEX_WIDTH-1:0] winner_index;
   logic                   release_ev;

   generate
      if (N == 1) begin : g_rot_single
         assign rot_grant = bus.grant;
      end else begin : g_rot_multi
         assign rot_grant = {bus.grant[N-2:0], bus.grant[N-1]};
      end
   endgenerate

   // Upper copy of the request vector supplies the wrapped-around candidates.
   always_comb begin
      release_ev   = bus.done || ((bus.requests & bus.grant) == '0);
      search_ptr   = (state == GRANTED) ? rot_grant : ptr;
      mask_lo      = ~(search_ptr - N'(1));
      doubled      = {bus.requests, bus.requests & mask_lo};
      first        = doubled & (~doubled + (2*N)'(1));
      winner       = first[N-1:0] | first[2*N-1:N];
      winner_index = '0;
      for (int i = 0; i < N; i++) begin
         if (winner[i]) winner_index = INDEX_WIDTH'(i);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state           <= IDLE;
         ptr             <= N'(1);
         bus.grant       <= '0;
         bus.grant_valid <= 1'b0;
         bus.grant_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.requests != '0) begin
                  bus.grant       <= winner;
                  bus.grant_index <= winner_index;
                  bus.grant_valid <= 1'b1;
                  state           <= GRANTED;
               end
            end
            GRANTED: begin
               if (release_ev) begin
                  ptr <= rot_grant;
                  if (bus.requests != '0) begin
                     bus.grant       <= winner;
                     bus.grant_index <= winner_index;
                     bus.grant_valid <= 1'b1;
                  end else begin
                     bus.grant       <= '0;
                     bus.grant_index <= '0;
                     bus.grant_valid <= 1'b0;
                     state           <= IDLE;
                  end
               end
            end
            default: begin
               state           <= IDLE;
               bus.grant       <= '0;
               bus.grant_index <= '0;
               bus.grant_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_round_robin_grant_generator.sv
// Self-checking bench: directed vector table with hand-derived grants, then
// randomized traffic checked against an independent scan-based reference model.
module tb_round_robin_grant_generator;
   localparam int N  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   round_robin_grant_generator_if #(.REQUESTER_COUNT(N), .INDEX_WIDTH(IW)) bus ();

   round_robin_grant_generator #(.REQUESTER_COUNT(N), .INDEX_WIDTH(IW)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic         rst_n;
      logic [N-1:0] req;
      logic         done;
      logic [N-1:0] exp_grant;
      string        name;
   } vec_t;

   typedef struct {
      logic [N-1:0]  grant;
      logic          valid;
      logic [IW-1:0] index;
      string         name;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   int    pass_cnt = 0;
   int    chk_cnt  = 0;

   logic [N-1:0] m_ptr   = 4'b0001;
   logic [N-1:0] m_grant = '0;

   function automatic logic [IW-1:0] g2i(input logic [N-1:0] g);
      logic [IW-1:0] r = '0;
      for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
      return r;
   endfunction

   function automatic logic [N-1:0] scan(input logic [N-1:0] p, input logic [N-1:0] r);
      int start = 0;
      for (int i = 0; i < N; i++) if (p[i]) start = i;
      for (int k = 0; k < N; k++) begin
         int j = (start + k) % N;
         if (r[j]) return N'(1) << j;
      end
      return '0;
   endfunction

   task automatic model_step(input logic rs, input logic [N-1:0] r, input logic d);
      if (!rs) begin
         m_ptr   = 4'b0001;
         m_grant = '0;
      end else if (m_grant == '0) begin
         m_grant = scan(m_ptr, r);
      end else if (d || ((r & m_grant) == '0)) begin
         m_ptr   = {m_grant[N-2:0], m_grant[N-1]};
         m_grant = scan(m_ptr, r);
      end
   endtask

   task automatic add(input logic rs, input logic [N-1:0] r, input logic d,
                      input logic [N-1:0] g, input string nm);
      vec_t v;
      v.rst_n = rs; v.req = r; v.done = d; v.exp_grant = g; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic rs, input logic [N-1:0] r, input logic d,
                        input logic [N-1:0] exp_g, input bit use_model, input string nm);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst_n        = rs;
      bus.requests = r;
      bus.done     = d;
      model_step(rs, r, d);
      e.grant = use_model ? m_grant : exp_g;
      e.valid = |e.grant;
      e.index = g2i(e.grant);
      e.name  = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk_cnt++;
      if (sb.size() == 0) begin
         $display("FAIL %s: scoreboard empty when output sampled", nm);
      end else begin
         got = sb.pop_front();
         if (bus.grant === got.grant && bus.grant_valid === got.valid &&
             bus.grant_index === got.index) begin
            pass_cnt++;
         end else begin
            $display("FAIL %s: got grant=%b valid=%b index=%0d, expected grant=%b valid=%b index=%0d",
                     got.name, bus.grant, bus.grant_valid, bus.grant_index,
                     got.grant, got.valid, got.index);
         end
      end
   endtask

   assert property (@(posedge clk) disable iff (!chk_en) $onehot0(bus.grant))
      else $error("FAIL onehot0: grant=%b", bus.grant);
   assert property (@(posedge clk) disable iff (!chk_en) bus.grant_valid == (|bus.grant))
      else $error("FAIL valid_or: valid=%b grant=%b", bus.grant_valid, bus.grant);
   assert property (@(posedge clk) disable iff (!chk_en)
                    (bus.grant == '0) ? (bus.grant_index == '0) : bus.grant[bus.grant_index])
      else $error("FAIL index_match: index=%0d grant=%b", bus.grant_index, bus.grant);
   assert property (@(posedge clk) disable iff (!chk_en) $onehot(dut.ptr))
      else $error("FAIL ptr_onehot: ptr=%b", dut.ptr);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.requests = '0;
      bus.done     = 1'b0;

      for (int i = 0; i < 3; i++) add(0, 4'b1111, 1, 4'b0000, "reset_hold");
      add(1, 4'b0100, 0, 4'b0100, "basic_grant");
      for (int i = 0; i < 4; i++) add(1, 4'b0100, 0, 4'b0100, "basic_hold");
      add(1, 4'b0000, 1, 4'b0000, "basic_release");
      add(1, 4'b0000, 0, 4'b0000, "idle_stay");
      add(1, 4'b0011, 0, 4'b0001, "wrap_first");
      add(1, 4'b0011, 0, 4'b0001, "wrap_hold");
      add(1, 4'b0011, 1, 4'b0010, "skip_next");
      add(1, 4'b0011, 0, 4'b0010, "skip_hold");
      add(1, 4'b1000, 0, 4'b1000, "req_drop");
      add(0, 4'b1001, 0, 4'b0000, "reset_mid_grant");
      add(1, 4'b1001, 0, 4'b0001, "post_reset_ptr0");
      add(1, 4'b1001, 1, 4'b1000, "post_reset_rotate");
      add(1, 4'b0000, 1, 4'b0000, "drain");
      add(1, 4'b1111, 0, 4'b0001, "rot_0");
      add(1, 4'b1111, 0, 4'b0001, "rot_0_hold");
      add(1, 4'b1111, 1, 4'b0010, "rot_1");
      add(1, 4'b1111, 0, 4'b0010, "rot_1_hold");
      add(1, 4'b1111, 0, 4'b0010, "rot_1_hold");
      add(1, 4'b1111, 1, 4'b0100, "rot_2");
      add(1, 4'b1111, 0, 4'b0100, "rot_2_hold");
      add(1, 4'b1111, 0, 4'b0100, "rot_2_hold");
      add(1, 4'b1111, 1, 4'b1000, "rot_3");
      add(1, 4'b1111, 0, 4'b1000, "rot_3_hold");
      add(1, 4'b1111, 0, 4'b1000, "rot_3_hold");
      add(1, 4'b1111, 1, 4'b0001, "rot_wrap");
      add(1, 4'b0100, 1, 4'b0100, "sole_first");
      add(1, 4'b0100, 1, 4'b0100, "sole_regrant");
      add(1, 4'b0100, 0, 4'b0100, "sole_hold");
      add(1, 4'b0000, 1, 4'b0000, "sole_release");
      add(1, 4'b0000, 1, 4'b0000, "idle_ignore_done");
      add(1, 4'b0010, 0, 4'b0010, "idle_from_ptr3");
      add(1, 4'b1111, 0, 4'b0010, "others_no_effect");

      foreach (vecs[i])
         apply(vecs[i].rst_n, vecs[i].req, vecs[i].done, vecs[i].exp_grant, 1'b0, vecs[i].name);

      // Continuous done with two requesters alternates every cycle.
      apply(1, 4'b0101, 1, 4'b0100, 1'b0, "alt_a");
      apply(1, 4'b0101, 1, 4'b0001, 1'b0, "alt_b");
      apply(1, 4'b0101, 1, 4'b0100, 1'b0, "alt_c");
      apply(1, 4'b0000, 0, 4'b0000, 1'b0, "alt_drop");

      for (int c = 0; c < 400; c++) begin
         logic         rs;
         logic [N-1:0] r;
         logic         d;
         rs = ($urandom_range(0, 39) != 0);
         r  = N'($urandom_range(0, 15));
         d  = ($urandom_range(0, 3) == 0);
         apply(rs, r, d, '0, 1'b1, "random");
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
